// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the regfile_sb register file and its scoreboard.
package regfile_pkg;

    localparam int DEF_DATA_W   = 4;
    localparam int DEF_NUM_REGS = 4;

    // Index width for a power-of-two register count (count is always >= 2).
    function automatic int addr_w(input int num_regs);
        return $clog2(num_regs);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: issue reserves a destination, writeback releases it.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = addr_w(NUM_REGS),
    parameter bit ZERO_R0  = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_rd,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic              busy1,
    output logic              busy2,
    output logic              iss_ready
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // NOTE: every output of this block is assigned before any conditional
    // update, so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        iss_ready = !busy_q[iss_rd] || (we && (waddr == iss_rd));
        if (ZERO_R0 && (iss_rd == '0)) begin
            iss_ready = 1'b1;
        end

        // Clear before set so a same-register issue wins over the writeback.
        busy_d = busy_q;
        if (we) begin
            busy_d[waddr] = 1'b0;
        end
        if (iss_valid && iss_ready) begin
            busy_d[iss_rd] = 1'b1;
        end
        if (ZERO_R0) begin
            busy_d[0] = 1'b0;
        end
    end

    // NOTE: state is updated with non-blocking assignments only; blocking
    // ones are reserved for the combinational next-state logic above.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy1 = busy_q[ra1];
    assign busy2 = busy_q[ra2];

endmodule

// File: rtl/regfile_sb.sv
// Two-read, one-write register file with issue scoreboard.
// Define REGFILE_SB_BYPASS_EN to forward same-cycle writeback data and busy release to the read ports.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter bit ZERO_R0  = 1'b0,
    parameter int ADDR_W   = addr_w(NUM_REGS)  // derived, leave at default
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              busy1,
    output logic              busy2,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_rd,
    output logic              iss_ready
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              sb_busy1;
    logic              sb_busy2;

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .ZERO_R0  (ZERO_R0)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (we),
        .waddr     (waddr),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .ra1       (ra1),
        .ra2       (ra2),
        .busy1     (sb_busy1),
        .busy2     (sb_busy2),
        .iss_ready (iss_ready)
    );

    always_comb begin
        regs_d = regs_q;
        if (we) begin
            regs_d[waddr] = wdata;
        end
        if (ZERO_R0) begin
            regs_d[0] = '0;
        end
    end

    // NOTE: the array is built from flops, not a RAM macro, because every
    // entry must clear asynchronously on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rd1   = regs_q[ra1];
        rd2   = regs_q[ra2];
        busy1 = sb_busy1;
        busy2 = sb_busy2;
`ifdef REGFILE_SB_BYPASS_EN
        if (we && (ra1 == waddr) && !(ZERO_R0 && (ra1 == '0))) begin
            rd1   = wdata;
            busy1 = 1'b0;
        end
        if (we && (ra2 == waddr) && !(ZERO_R0 && (ra2 == '0))) begin
            rd2   = wdata;
            busy2 = 1'b0;
        end
`endif
    end

endmodule
